// File: rtl/bus_phase_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_phase_sequencer_pkg
// Purpose  : Shared types for the bus phase sequencer. Holds the state
//            encoding, the debug timer width, the registered output bundle
//            and the state-to-output decode helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bus_phase_sequencer_pkg;

  localparam int TIMER_W = 4;

  typedef enum logic [3:0] {
    ST_RST     = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_EXECUTE = 4'd3,
    ST_COMMIT  = 4'd4,
    ST_HALT    = 4'd5,
    ST_DBG_RD  = 4'd6,
    ST_DBG_WR  = 4'd7,
    ST_DBG_ACK = 4'd8
  } state_t;

  typedef struct packed {
    logic fetch;
    logic decode;
    logic execute;
    logic commit;
    logic stopped;
    logic debug;
    logic rd;
    logic wr;
    logic ack;
  } outs_t;

  // Every output is a pure function of the machine state, so the same
  // decode serves the output register regardless of where the state is.
  function automatic outs_t decode_outputs(input state_t s);
    outs_t o;
    o = '0;
    case (s)
      ST_FETCH:   o.fetch   = 1'b1;
      ST_DECODE:  o.decode  = 1'b1;
      ST_EXECUTE: o.execute = 1'b1;
      ST_COMMIT:  o.commit  = 1'b1;
      ST_HALT: begin
        o.stopped = 1'b1;
        o.debug   = 1'b1;
      end
      ST_DBG_RD: begin
        o.stopped = 1'b1;
        o.debug   = 1'b1;
        o.rd      = 1'b1;
      end
      ST_DBG_WR: begin
        o.stopped = 1'b1;
        o.debug   = 1'b1;
        o.wr      = 1'b1;
      end
      ST_DBG_ACK: begin
        o.stopped = 1'b1;
        o.debug   = 1'b1;
        o.ack     = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_phase_sequencer_timer.sv
`default_nettype none
// ============================================================================
// Module   : bus_access_timer
// Purpose  : Load / decrement / zero-flag down-counter that times the debug
//            read and write strobes. Saturates at zero, never wraps.
// Ports    : clk        in  clock
//            rst        in  synchronous active-high reset
//            load       in  load load_value (takes priority over dec)
//            load_value in  TIMER_W value to load
//            dec        in  decrement by one while non-zero
//            zero       out counter is zero
// Revision : 1.0 - initial release
// ============================================================================
module bus_access_timer #(
  parameter int TIMER_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  input  logic               dec,
  output logic               zero
);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/bus_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bus_phase_sequencer
// Purpose  : Master machine-cycle sequencer. Generates one-hot FETCH, DECODE,
//            EXECUTE, COMMIT phases, stretches EXECUTE for memory waits,
//            halts at an instruction boundary on debug request and, while
//            halted, grants the bus to the debug port for timed accesses.
// Ports    : CLK          in  clock, all state changes on rising edge
//            RESET        in  synchronous active-high reset
//            MEM_WAIT     in  memory not ready (EXECUTE only)
//            DEBUG_STOP   in  halt request level (COMMIT and HALT)
//            DEBUG_STEP   in  single-step pulse (HALT only)
//            DEBUG_RD_REQ in  debug read request level
//            DEBUG_WR_REQ in  debug write request level
//            FETCH/DECODE/EXECUTE/COMMIT out one-hot phase strobes
//            STOPPED      out halted at instruction boundary
//            DEBUG_DEBUG  out bus owned by debug port
//            DEBUG_RD     out debug read strobe
//            DEBUG_WR     out debug write strobe
//            DEBUG_ACK    out one-cycle debug access completion
// Params   : DBG_ACCESS_CYCLES strobe length per debug access, 1..15
// Revision : 1.0 - initial release
// ============================================================================
module bus_phase_sequencer #(
  parameter int DBG_ACCESS_CYCLES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic MEM_WAIT,
  input  logic DEBUG_STOP,
  input  logic DEBUG_STEP,
  input  logic DEBUG_RD_REQ,
  input  logic DEBUG_WR_REQ,
  output logic FETCH,
  output logic DECODE,
  output logic EXECUTE,
  output logic COMMIT,
  output logic STOPPED,
  output logic DEBUG_DEBUG,
  output logic DEBUG_RD,
  output logic DEBUG_WR,
  output logic DEBUG_ACK
);

  import bus_phase_sequencer_pkg::*;

  localparam logic [TIMER_W-1:0] c_load_value = TIMER_W'(DBG_ACCESS_CYCLES - 1);

  state_t r_state;
  state_t w_state_next;
  outs_t  r_outs;
  logic   r_step_pending;
  logic   w_load;
  logic   w_step_set;
  logic   w_step_clr;
  logic   w_timer_zero;
  logic   w_in_access;

  assign w_in_access = (r_state == ST_DBG_RD) || (r_state == ST_DBG_WR);

  bus_access_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk        (CLK),
    .rst        (RESET),
    .load       (w_load),
    .load_value (c_load_value),
    .dec        (w_in_access),
    .zero       (w_timer_zero)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state        <= ST_RST;
      r_step_pending <= 1'b0;
      r_outs         <= '0;
    end else begin
      r_state <= w_state_next;
      // Outputs are decoded from the next state so they line up with the
      // state register while still coming straight out of flops.
      r_outs  <= decode_outputs(w_state_next);
      if (w_step_set) begin
        r_step_pending <= 1'b1;
      end else if (w_step_clr) begin
        r_step_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step_set   = 1'b0;
    w_step_clr   = 1'b0;
    case (r_state)
      ST_RST:     w_state_next = ST_FETCH;
      ST_FETCH:   w_state_next = ST_DECODE;
      ST_DECODE:  w_state_next = ST_EXECUTE;
      ST_EXECUTE: begin
        if (!MEM_WAIT) begin
          w_state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        // A pending step always ends here, so clearing unconditionally is
        // equivalent to clearing on the halt branch only.
        w_step_clr = 1'b1;
        if (DEBUG_STOP || r_step_pending) begin
          w_state_next = ST_HALT;
        end else begin
          w_state_next = ST_FETCH;
        end
      end
      ST_HALT: begin
        if (DEBUG_RD_REQ) begin
          w_state_next = ST_DBG_RD;
          w_load       = 1'b1;
        end else if (DEBUG_WR_REQ) begin
          w_state_next = ST_DBG_WR;
          w_load       = 1'b1;
        end else if (DEBUG_STEP) begin
          w_state_next = ST_FETCH;
          w_step_set   = 1'b1;
        end else if (!DEBUG_STOP) begin
          w_state_next = ST_FETCH;
        end
      end
      ST_DBG_RD, ST_DBG_WR: begin
        if (w_timer_zero) begin
          w_state_next = ST_DBG_ACK;
        end
      end
      ST_DBG_ACK: w_state_next = ST_HALT;
      default:    w_state_next = ST_RST;
    endcase
  end

  assign FETCH       = r_outs.fetch;
  assign DECODE      = r_outs.decode;
  assign EXECUTE     = r_outs.execute;
  assign COMMIT      = r_outs.commit;
  assign STOPPED     = r_outs.stopped;
  assign DEBUG_DEBUG = r_outs.debug;
  assign DEBUG_RD    = r_outs.rd;
  assign DEBUG_WR    = r_outs.wr;
  assign DEBUG_ACK   = r_outs.ack;

endmodule
`default_nettype wire

// File: tb/tb_bus_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_phase_sequencer
// Purpose  : Self-checking bench for bus_phase_sequencer. A directed table of
//            per-cycle inputs and expected outputs, followed by random
//            stimulus compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_phase_sequencer;

  localparam int N = 2;

  // Output bit order: F D E C STOPPED DEBUG RD WR ACK
  localparam logic [8:0] O_0 = 9'h000;
  localparam logic [8:0] O_F = 9'h100;
  localparam logic [8:0] O_D = 9'h080;
  localparam logic [8:0] O_E = 9'h040;
  localparam logic [8:0] O_C = 9'h020;
  localparam logic [8:0] O_H = 9'h018;
  localparam logic [8:0] O_R = 9'h01C;
  localparam logic [8:0] O_W = 9'h01A;
  localparam logic [8:0] O_A = 9'h019;

  logic CLK = 1'b0;
  logic RESET, MEM_WAIT, DEBUG_STOP, DEBUG_STEP, DEBUG_RD_REQ, DEBUG_WR_REQ;
  logic FETCH, DECODE, EXECUTE, COMMIT, STOPPED, DEBUG_DEBUG;
  logic DEBUG_RD, DEBUG_WR, DEBUG_ACK;

  bus_phase_sequencer #(.DBG_ACCESS_CYCLES(N)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .MEM_WAIT     (MEM_WAIT),
    .DEBUG_STOP   (DEBUG_STOP),
    .DEBUG_STEP   (DEBUG_STEP),
    .DEBUG_RD_REQ (DEBUG_RD_REQ),
    .DEBUG_WR_REQ (DEBUG_WR_REQ),
    .FETCH        (FETCH),
    .DECODE       (DECODE),
    .EXECUTE      (EXECUTE),
    .COMMIT       (COMMIT),
    .STOPPED      (STOPPED),
    .DEBUG_DEBUG  (DEBUG_DEBUG),
    .DEBUG_RD     (DEBUG_RD),
    .DEBUG_WR     (DEBUG_WR),
    .DEBUG_ACK    (DEBUG_ACK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst, mw, stop, step, rd, wr;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];
  int tests = 0;
  int fails = 0;

  // Behavioural model: the CPU is either in reset, running phase k of an
  // instruction, halted, doing a debug access with some cycles left, or
  // acknowledging one.
  int m_mode = 0;  // 0 reset, 1 running, 2 halted, 3 access, 4 ack
  int m_phase = 0;
  int m_left = 0;
  bit m_is_wr = 1'b0;
  bit m_step = 1'b0;

  function automatic void model_step(input logic rst, mw, stop, step, rd, wr);
    if (rst) begin
      m_mode = 0;
      m_step = 1'b0;
    end else begin
      case (m_mode)
        0: begin m_mode = 1; m_phase = 0; end
        1: begin
          if (m_phase == 3) begin
            if (stop || m_step) begin m_mode = 2; m_step = 1'b0; end
            else m_phase = 0;
          end else if (!(m_phase == 2 && mw)) begin
            m_phase = m_phase + 1;
          end
        end
        2: begin
          if (rd)        begin m_mode = 3; m_is_wr = 1'b0; m_left = N; end
          else if (wr)   begin m_mode = 3; m_is_wr = 1'b1; m_left = N; end
          else if (step) begin m_mode = 1; m_phase = 0; m_step = 1'b1; end
          else if (!stop) begin m_mode = 1; m_phase = 0; end
        end
        3: begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = 4;
        end
        default: m_mode = 2;
      endcase
    end
  endfunction

  function automatic logic [8:0] model_outs();
    logic [8:0] o;
    o = '0;
    if (m_mode == 1) o[8 - m_phase] = 1'b1;
    if (m_mode >= 2) o[4:3] = 2'b11;
    if (m_mode == 3) begin
      if (m_is_wr) o[1] = 1'b1;
      else         o[2] = 1'b1;
    end
    if (m_mode == 4) o[0] = 1'b1;
    return o;
  endfunction

  function automatic logic [8:0] dut_outs();
    return {FETCH, DECODE, EXECUTE, COMMIT, STOPPED, DEBUG_DEBUG,
            DEBUG_RD, DEBUG_WR, DEBUG_ACK};
  endfunction

  task automatic add(input logic rst, mw, stop, step, rd, wr, input logic [8:0] exp);
    vec_t v;
    v.rst = rst; v.mw = mw; v.stop = stop; v.step = step; v.rd = rd; v.wr = wr;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  // Inputs change just after the falling edge; outputs are read at the
  // next falling edge, half a cycle after the rising edge that moved them.
  task automatic drive(input logic rst, mw, stop, step, rd, wr);
    RESET = rst; MEM_WAIT = mw; DEBUG_STOP = stop;
    DEBUG_STEP = step; DEBUG_RD_REQ = rd; DEBUG_WR_REQ = wr;
    @(posedge CLK);
    model_step(rst, mw, stop, step, rd, wr);
    @(negedge CLK);
  endtask

  task automatic check(input string name, input logic [8:0] exp);
    tests++;
    if (dut_outs() !== exp) begin
      fails++;
      $display("FAIL %s: outputs %b, expected %b", name, dut_outs(), exp);
    end
  endtask

  initial begin
    RESET = 1'b1; MEM_WAIT = 1'b0; DEBUG_STOP = 1'b0;
    DEBUG_STEP = 1'b0; DEBUG_RD_REQ = 1'b0; DEBUG_WR_REQ = 1'b0;

    //   rst  mw   stop step rd   wr    expected
    // reset and free-running cycle, MEM_WAIT in FETCH ignored
    add(1, 0, 0, 0, 0, 0, O_0);
    add(1, 0, 0, 0, 0, 0, O_0);
    add(0, 0, 0, 0, 0, 0, O_F);
    add(0, 0, 0, 0, 0, 0, O_D);
    add(0, 0, 0, 0, 0, 0, O_E);
    add(0, 0, 0, 0, 0, 0, O_C);
    add(0, 0, 0, 0, 0, 0, O_F);
    add(0, 1, 0, 0, 0, 0, O_D);
    // EXECUTE stretched by three wait cycles
    add(0, 0, 0, 0, 0, 0, O_E);
    add(0, 1, 0, 0, 0, 0, O_E);
    add(0, 1, 0, 0, 0, 0, O_E);
    add(0, 1, 0, 0, 0, 0, O_E);
    add(0, 0, 0, 0, 0, 0, O_C);
    // STOP raised in DECODE halts after that instruction's COMMIT
    add(0, 0, 0, 0, 0, 0, O_F);
    add(0, 0, 0, 0, 0, 0, O_D);
    add(0, 0, 1, 0, 0, 0, O_E);
    add(0, 0, 1, 0, 0, 0, O_C);
    add(0, 0, 1, 0, 0, 0, O_H);
    add(0, 0, 1, 0, 0, 0, O_H);
    add(0, 0, 0, 0, 0, 0, O_F);
    add(0, 0, 1, 0, 0, 0, O_D);
    add(0, 0, 1, 0, 0, 0, O_E);
    add(0, 0, 1, 0, 0, 0, O_C);
    add(0, 0, 1, 0, 0, 0, O_H);
    // simultaneous read and write: read first, then the write
    add(0, 0, 1, 0, 1, 1, O_R);
    add(0, 0, 1, 0, 1, 1, O_R);
    add(0, 0, 1, 0, 1, 1, O_A);
    add(0, 0, 1, 0, 0, 1, O_H);
    add(0, 0, 1, 0, 0, 1, O_W);
    add(0, 0, 1, 0, 0, 1, O_W);
    add(0, 0, 1, 0, 0, 1, O_A);
    add(0, 0, 1, 0, 0, 0, O_H);
    // single step while STOP held
    add(0, 0, 1, 1, 0, 0, O_F);
    add(0, 0, 1, 0, 0, 0, O_D);
    add(0, 0, 1, 0, 0, 0, O_E);
    add(0, 0, 1, 0, 0, 0, O_C);
    add(0, 0, 1, 0, 0, 0, O_H);
    add(0, 0, 1, 0, 0, 0, O_H);
    // reset in the second write-strobe cycle
    add(0, 0, 1, 0, 0, 1, O_W);
    add(0, 0, 1, 0, 0, 1, O_W);
    add(1, 0, 1, 0, 0, 1, O_0);
    add(0, 0, 0, 0, 0, 0, O_F);
    add(0, 0, 0, 0, 0, 0, O_D);

    @(negedge CLK);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].mw, vecs[i].stop, vecs[i].step,
            vecs[i].rd, vecs[i].wr);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic r_rst, r_mw, r_stop, r_step, r_rd, r_wr;
      r_rst  = ($urandom_range(0, 99) == 0);
      r_mw   = ($urandom_range(0, 2) == 0);
      r_stop = ($urandom_range(0, 3) != 0);
      r_step = ($urandom_range(0, 5) == 0);
      r_rd   = ($urandom_range(0, 4) == 0);
      r_wr   = ($urandom_range(0, 4) == 0);
      drive(r_rst, r_mw, r_stop, r_step, r_rd, r_wr);
      check($sformatf("rand%0d", i), model_outs());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
